seq_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse of the team's combinational array multiplier.
- Takes a 2W-bit product-width dividend and a W-bit divisor; returns a W-bit quotient and a W-bit remainder.
- Sits downstream of the multiplier datapath and uses valid/ready handshakes on both sides.
- Retires one quotient bit per cycle.

---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 2W-bit dividend by W-bit divisor.
// Define SEQ_DIVIDER_EARLY_OVF_EN to skip CALC when the quotient overflows.
module seq_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  lo_q;
  logic          ovf_c_q;
  logic          dz_c_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  quotient_q;
  logic [W-1:0]  remainder_q;
  logic          ovf_q;
  logic          dz_q;

  logic          accept;
  logic          ovf_in;
  logic          dz_in;
  logic [W:0]    rem_sh;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  quo_d;

  assign accept = in_valid & in_ready_q;
  assign ovf_in = dividend[2*W-1:W] >= divisor;
  assign dz_in  = divisor == '0;

  // The remainder only needs W+1 bits during the trial subtract;
  // once restored it is below the divisor and fits in W bits again.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    ge     = rem_sh >= {1'b0, dvs_q};
    rem_d  = ge ? trial[W-1:0] : rem_sh[W-1:0];
    quo_d  = {quo_q[W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      lo_q        <= '0;
      ovf_c_q     <= 1'b0;
      dz_c_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dvs_q      <= divisor;
            lo_q       <= dividend[W-1:0];
            rem_q      <= dividend[2*W-1:W];
            quo_q      <= dividend[W-1:0];
            ovf_c_q    <= ovf_in;
            dz_c_q     <= dz_in;
            cnt_q      <= CW'(W - 1);
            in_ready_q <= 1'b0;
`ifdef SEQ_DIVIDER_EARLY_OVF_EN
            state_q    <= ovf_in ? DONE : CALC;
`else
            state_q    <= CALC;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            if (ovf_c_q) begin
              quotient_q  <= '1;
              remainder_q <= lo_q;
              ovf_q       <= 1'b1;
              dz_q        <= dz_c_q;
            end else begin
              quotient_q  <= quo_d;
              remainder_q <= rem_d;
              ovf_q       <= 1'b0;
              dz_q        <= 1'b0;
            end
          end
        end
        DONE: begin
          // Arriving without out_valid means CALC was skipped on overflow.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= lo_q;
            ovf_q       <= 1'b1;
            dz_q        <= dz_c_q;
          end else if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider at W=4
// against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           dz;

  int nvec = 0;
  int nerr = 0;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division plus the overflow forcing rule.
  task automatic model(input int a, input int b, output int q,
                       output int r, output int v, output int z,
                       output int lat);
    v = ((a >> W) >= b) ? 1 : 0;
    z = (b == 0) ? 1 : 0;
    if (v == 1) begin
      q = (1 << W) - 1;
      r = a % (1 << W);
    end else begin
      q = a / b;
      r = a % b;
    end
    lat = W;
`ifdef SEQ_DIVIDER_EARLY_OVF_EN
    if (v == 1) lat = 1;
`endif
  endtask

  task automatic run_op(input int a, input int b, input int hold);
    int q, r, v, z, elat, lat, n;
    model(a, b, q, r, v, z, elat);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before", in_ready, 1);
    dividend  = (2*W)'(a);
    divisor   = W'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    dividend = (2*W)'($urandom);
    divisor  = W'($urandom);
    chk("in_ready_after_accept", in_ready, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", lat, elat);
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    chk("ovf", ovf, v);
    chk("dz", dz, z);
    chk("in_ready_in_done", in_ready, 0);
    if (v == 0) chk("invariant", quotient * b + remainder, a);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_q", quotient, q);
      chk("hold_r", remainder, r);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("valid_fall", out_valid, 0);
    chk("in_ready_rise", in_ready, 1);
    chk("q_kept", quotient, q);
    out_ready = 1'b0;
  endtask

  initial begin
    int q, r, v, z, el, a, b, seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    run_op(143, 13, 0);
    run_op(200, 15, 0);
    run_op(0, 1, 0);
    run_op(240, 15, 0);
    run_op(37, 0, 0);
    run_op(99, 7, 6);

    // Back-to-back: in_valid held high across two requests.
    dividend  = 8'd143;
    divisor   = 4'd13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("b2b_accept1", in_ready, 0);
    dividend = 8'd200;
    divisor  = 4'd15;
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("b2b_q1", quotient, 11);
    chk("b2b_r1", remainder, 0);
    tick();
    chk("b2b_idle_ready", in_ready, 1);
    tick();
    chk("b2b_accept2", in_ready, 0);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("b2b_q2", quotient, 13);
    chk("b2b_r2", remainder, 5);
    tick();
    out_ready = 1'b0;

    // Reset pulse landing on the second CALC iteration.
    dividend = 8'd143;
    divisor  = 4'd13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_dz", dz, 0);
    chk("abort_in_ready", in_ready, 0);
    tick();
    chk("abort_rel_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_pulse", seen, 0);
    run_op(143, 13, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 8 == 0) ? 0 : $urandom_range(0, 15);
      run_op(a, b, $urandom_range(0, 2));
    end

    model(143, 13, q, r, v, z, el);
    chk("model_sanity", q * 13 + r, 143);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
